// File: rtl/mc_exec_scheduler.sv
// rtl/mc_exec_scheduler.sv - launch, hazard stall and write-port scheduling for the multiplier and FPU
// Unit 0 is the multiplier and unit 1 is the FPU. Both units share one per-unit FSM description.
module mc_exec_scheduler #(
  parameter int TIMEOUT = 64,
  parameter int DW      = 32
) (
  input  logic          CLK,
  input  logic          ResetN,
  input  logic          MStart,
  input  logic          FPUStart,
  input  logic [3:0]    RdE,
  input  logic          MReqD,
  input  logic          FPUReqD,
  input  logic [3:0]    Ra1D,
  input  logic [3:0]    Ra2D,
  input  logic          UseRa1D,
  input  logic          UseRa2D,
  input  logic          RegWD,
  input  logic [3:0]    RdD,
  input  logic          MDone,
  input  logic [DW-1:0] MResult,
  input  logic          FPUDone,
  input  logic [DW-1:0] FPUResult,
  input  logic          RegWriteW,
  output logic          MGo,
  output logic          FPUGo,
  output logic          StallD,
  output logic          MCWE,
  output logic [3:0]    MCWA,
  output logic [DW-1:0] MCWD,
  output logic          MBusy,
  output logic          FPUBusy,
  output logic          TimeoutErr,
  output logic          ProtoErr
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, WB = 2'd2} state_t;

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t        st      [2];
  logic [3:0]    pend_rd [2];
  logic [DW-1:0] hold    [2];
  logic [CW-1:0] cnt     [2];
  logic [DW-1:0] result  [2];
  logic [1:0]    start, done, busy, accept, grant, go;
  logic          m_older;
  logic          any_start;

  assign start     = {FPUStart, MStart};
  assign done      = {FPUDone, MDone};
  assign result[0] = MResult;
  assign result[1] = FPUResult;
  assign busy[0]   = (st[0] != IDLE);
  assign busy[1]   = (st[1] != IDLE);
  assign accept    = start & ~busy;
  assign any_start = MStart | FPUStart;

  // A unit's PendRd is valid exactly while that unit is not IDLE.
  function automatic logic hazard(input logic [3:0] r);
    return (busy[0] && (r == pend_rd[0])) ||
           (busy[1] && (r == pend_rd[1])) ||
           (any_start && (r == RdE));
  endfunction

  assign StallD = (MReqD && busy[0]) || (FPUReqD && busy[1]) ||
                  (UseRa1D && hazard(Ra1D)) || (UseRa2D && hazard(Ra2D)) ||
                  (RegWD && hazard(RdD));

  // Main pipeline writeback always has priority; between units the older issue wins.
  assign grant[0] = (st[0] == WB) && !RegWriteW && ((st[1] != WB) || m_older);
  assign grant[1] = (st[1] == WB) && !RegWriteW && ((st[0] != WB) || !m_older);

  assign MCWE    = |grant;
  assign MCWA    = grant[0] ? pend_rd[0] : (grant[1] ? pend_rd[1] : 4'd0);
  assign MCWD    = grant[0] ? hold[0] : (grant[1] ? hold[1] : '0);
  assign MGo     = go[0];
  assign FPUGo   = go[1];
  assign MBusy   = busy[0];
  assign FPUBusy = busy[1];

  always_ff @(posedge CLK or negedge ResetN) begin
    if (!ResetN) begin
      for (int i = 0; i < 2; i++) begin
        st[i]      <= IDLE;
        pend_rd[i] <= '0;
        hold[i]    <= '0;
        cnt[i]     <= '0;
      end
      go         <= '0;
      m_older    <= 1'b0;
      TimeoutErr <= 1'b0;
      ProtoErr   <= 1'b0;
    end else begin
      go <= accept;
      if (|(start & busy))
        ProtoErr <= 1'b1;
      // Issuing while the other unit is busy makes the issuing unit the younger one.
      if (accept == 2'b11)
        m_older <= 1'b1;
      else if (accept[0])
        m_older <= !busy[1];
      else if (accept[1])
        m_older <= busy[0];
      for (int i = 0; i < 2; i++) begin
        case (st[i])
          IDLE: if (accept[i]) begin
            pend_rd[i] <= RdE;
            cnt[i]     <= '0;
            st[i]      <= RUN;
          end
          RUN: begin
            cnt[i] <= cnt[i] + 1'b1;
            if (done[i]) begin
              hold[i] <= result[i];
              st[i]   <= WB;
            end else if ((TIMEOUT != 0) && (cnt[i] == CW'(TIMEOUT - 1))) begin
              st[i]      <= IDLE;
              TimeoutErr <= 1'b1;
            end
          end
          WB: if (grant[i]) st[i] <= IDLE;
          default: st[i] <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_mc_exec_scheduler.sv
// tb/tb_mc_exec_scheduler.sv - directed and randomized checks against a transaction-level model
module tb_mc_exec_scheduler;
  localparam int TO = 8;

  logic        CLK = 1'b0;
  logic        ResetN = 1'b1;
  logic        MStart, FPUStart, MReqD, FPUReqD, UseRa1D, UseRa2D, RegWD;
  logic        MDone, FPUDone, RegWriteW;
  logic [3:0]  RdE, Ra1D, Ra2D, RdD;
  logic [31:0] MResult, FPUResult;
  logic        MGo, FPUGo, StallD, MCWE, MBusy, FPUBusy, TimeoutErr, ProtoErr;
  logic [3:0]  MCWA;
  logic [31:0] MCWD;

  always #5 CLK = ~CLK;

  mc_exec_scheduler #(.TIMEOUT(TO), .DW(32)) dut (
    .CLK(CLK), .ResetN(ResetN), .MStart(MStart), .FPUStart(FPUStart), .RdE(RdE),
    .MReqD(MReqD), .FPUReqD(FPUReqD), .Ra1D(Ra1D), .Ra2D(Ra2D), .UseRa1D(UseRa1D),
    .UseRa2D(UseRa2D), .RegWD(RegWD), .RdD(RdD), .MDone(MDone), .MResult(MResult),
    .FPUDone(FPUDone), .FPUResult(FPUResult), .RegWriteW(RegWriteW), .MGo(MGo),
    .FPUGo(FPUGo), .StallD(StallD), .MCWE(MCWE), .MCWA(MCWA), .MCWD(MCWD),
    .MBusy(MBusy), .FPUBusy(FPUBusy), .TimeoutErr(TimeoutErr), .ProtoErr(ProtoErr)
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Transaction model: each unit holds at most one outstanding operation.
  bit          live [2];
  bit          rdy  [2];
  logic [3:0]  rd   [2];
  logic [31:0] dat  [2];
  int          runlen [2];
  int          ser  [2];
  bit          go_q [2];
  int          next_ser;
  bit          terr, perr;
  int          wr_cnt;
  logic [3:0]  wq [$];
  logic [31:0] last_wd;

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      live[u] = 0; rdy[u] = 0; rd[u] = 0; dat[u] = 0; runlen[u] = 0; ser[u] = 0; go_q[u] = 0;
    end
    next_ser = 0; terr = 0; perr = 0;
  endtask

  function automatic bit haz(input logic [3:0] r);
    return (live[0] && r == rd[0]) || (live[1] && r == rd[1]) || ((MStart || FPUStart) && r == RdE);
  endfunction

  task automatic eval();
    bit          st [2];
    bit          dn [2];
    logic [31:0] res [2];
    int          win;
    bit          exp_stall;
    st[0] = MStart; st[1] = FPUStart; dn[0] = MDone; dn[1] = FPUDone;
    res[0] = MResult; res[1] = FPUResult;
    win = -1;
    if (!RegWriteW)
      for (int u = 0; u < 2; u++)
        if (live[u] && rdy[u] && (win < 0 || ser[u] < ser[win])) win = u;
    exp_stall = (MReqD && live[0]) || (FPUReqD && live[1]) || (UseRa1D && haz(Ra1D)) ||
                (UseRa2D && haz(Ra2D)) || (RegWD && haz(RdD));
    chk("mgo", MGo, go_q[0]);
    chk("fpugo", FPUGo, go_q[1]);
    chk("mbusy", MBusy, live[0]);
    chk("fpubusy", FPUBusy, live[1]);
    chk("stalld", StallD, exp_stall);
    chk("mcwe", MCWE, win >= 0);
    chk("timeouterr", TimeoutErr, terr);
    chk("protoerr", ProtoErr, perr);
    if (win >= 0) begin
      chk("mcwa", MCWA, rd[win]);
      chk("mcwd", MCWD, dat[win]);
    end
    if (MCWE === 1'b1) begin
      wr_cnt++;
      wq.push_back(MCWA);
      last_wd = MCWD;
    end
    for (int u = 0; u < 2; u++) begin
      go_q[u] = st[u] && !live[u];
      if (st[u] && live[u]) perr = 1;
      if (live[u]) begin
        if (!rdy[u]) begin
          if (dn[u]) begin rdy[u] = 1; dat[u] = res[u]; end
          else if (runlen[u] == TO - 1) begin live[u] = 0; terr = 1; end
          else runlen[u]++;
        end else if (u == win) begin
          live[u] = 0;
        end
      end
    end
    for (int u = 0; u < 2; u++)
      if (go_q[u]) begin
        live[u] = 1; rdy[u] = 0; rd[u] = RdE; runlen[u] = 0; ser[u] = next_ser; next_ser++;
      end
  endtask

  task automatic clear_inputs();
    MStart = 0; FPUStart = 0; RdE = 0; MReqD = 0; FPUReqD = 0; Ra1D = 0; Ra2D = 0;
    UseRa1D = 0; UseRa2D = 0; RegWD = 0; RdD = 0; MDone = 0; MResult = 0;
    FPUDone = 0; FPUResult = 0; RegWriteW = 0;
  endtask

  task automatic cycle();
    @(negedge CLK);
    eval();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    ResetN = 0;
    clear_inputs();
    #1;
    chk("rst_mgo", MGo, 0);
    chk("rst_fpugo", FPUGo, 0);
    chk("rst_stalld", StallD, 0);
    chk("rst_mcwe", MCWE, 0);
    chk("rst_mcwa", MCWA, 0);
    chk("rst_mcwd", MCWD, 0);
    chk("rst_mbusy", MBusy, 0);
    chk("rst_fpubusy", FPUBusy, 0);
    chk("rst_terr", TimeoutErr, 0);
    chk("rst_perr", ProtoErr, 0);
    model_reset();
    @(posedge CLK);
    #1;
    ResetN = 1;
  endtask

  int done_pct;

  initial begin
    clear_inputs();
    #1;
    do_reset();

    // Single multiply, result two cycles after MGo.
    wr_cnt = 0;
    MStart = 1; RdE = 5; cycle(); clear_inputs();
    cycle(); cycle();
    MDone = 1; MResult = 32'h30; cycle(); clear_inputs();
    repeat (3) cycle();
    chk("s1_nwr", wr_cnt, 1);
    chk("s1_wd", last_wd, 32'h30);

    // RAW stall on pending Rd=5 until the unit is idle, then an unrelated source.
    UseRa1D = 1; Ra1D = 5;
    MStart = 1; RdE = 5; cycle(); MStart = 0; RdE = 0;
    repeat (3) cycle();
    MDone = 1; MResult = 32'h1234; cycle(); MDone = 0;
    repeat (3) cycle();
    Ra1D = 6; MStart = 1; RdE = 5; cycle(); MStart = 0;
    repeat (2) cycle();
    MDone = 1; cycle(); clear_inputs();
    repeat (3) cycle();

    // Both units finish together: older multiply writes first.
    wq.delete();
    MStart = 1; RdE = 3; cycle(); clear_inputs();
    cycle();
    FPUStart = 1; RdE = 4; cycle(); clear_inputs();
    repeat (2) cycle();
    MDone = 1; FPUDone = 1; MResult = 32'hAAAA_0003; FPUResult = 32'hBBBB_0004; cycle(); clear_inputs();
    repeat (4) cycle();
    chk("s3_nwr", wq.size(), 2);
    if (wq.size() >= 2) begin
      chk("s3_first", wq[0], 3);
      chk("s3_second", wq[1], 4);
    end

    // Write port held by the main pipeline for three cycles.
    MStart = 1; RdE = 7; cycle(); clear_inputs();
    cycle();
    MDone = 1; MResult = 32'hCAFE_0007; cycle(); clear_inputs();
    RegWriteW = 1; repeat (3) cycle();
    RegWriteW = 0; repeat (2) cycle();

    // FPU timeout, late Done ignored.
    wr_cnt = 0;
    FPUStart = 1; RdE = 9; cycle(); clear_inputs();
    repeat (12) cycle();
    FPUDone = 1; FPUResult = 32'hDEAD; cycle(); clear_inputs();
    repeat (2) cycle();
    chk("s5_terr", TimeoutErr, 1);
    chk("s5_nwr", wr_cnt, 0);

    // Reset during RUN, stale Done, then a protocol violation.
    MStart = 1; RdE = 2; cycle(); clear_inputs();
    repeat (2) cycle();
    do_reset();
    wr_cnt = 0;
    MDone = 1; MResult = 32'h77; cycle(); clear_inputs();
    repeat (2) cycle();
    chk("s6_nwr", wr_cnt, 0);
    MStart = 1; RdE = 1; cycle();
    RdE = 2; cycle(); clear_inputs();
    cycle();
    chk("s6_perr", ProtoErr, 1);

    // Randomized traffic against the model.
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      done_pct = ((n / 500) % 2 == 1) ? 5 : 35;
      MStart    = ($urandom_range(0, 3) == 0) && (!live[0] || $urandom_range(0, 99) == 0);
      FPUStart  = ($urandom_range(0, 3) == 0) && (!live[1] || $urandom_range(0, 99) == 0);
      RdE       = 4'($urandom_range(0, 7));
      MReqD     = $urandom_range(0, 1) == 1;
      FPUReqD   = $urandom_range(0, 1) == 1;
      Ra1D      = 4'($urandom_range(0, 7));
      Ra2D      = 4'($urandom_range(0, 7));
      UseRa1D   = $urandom_range(0, 1) == 1;
      UseRa2D   = $urandom_range(0, 1) == 1;
      RegWD     = $urandom_range(0, 1) == 1;
      RdD       = 4'($urandom_range(0, 7));
      MDone     = $urandom_range(0, 99) < done_pct;
      FPUDone   = $urandom_range(0, 99) < done_pct;
      MResult   = $urandom();
      FPUResult = $urandom();
      RegWriteW = $urandom_range(0, 99) < 40;
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mc_exec_scheduler.md
Name: mc_exec_scheduler

Overview:
- Sequences the multi-cycle execution units (integer multiplier, FPU) that are launched by the CondEx-qualified MStart/FPUStart strobes.
- Tracks each unit's busy state and destination register, and generates the Decode-stage stall for structural and RAW/WAW hazards.
- Arbitrates the shared register-file write port between unit results and the main pipeline's writeback.
- Sits between the Execute-stage condition logic, the two units and the register file.

Parameters:
- TIMEOUT, 64: cycles a unit may stay in RUN without Done before it is aborted; 0 disables the timeout.
- DW, 32: result data width.

Ports:
- CLK  in  1  clock, rising edge.
- ResetN  in  1  asynchronous, active-low reset.
- MStart  in  1  Execute: launch multiply (already CondEx-qualified).
- FPUStart  in  1  Execute: launch FPU op.
- RdE  in  4  destination register of the Execute instruction.
- MReqD  in  1  Decode instruction needs the multiplier.
- FPUReqD  in  1  Decode instruction needs the FPU.
- Ra1D, Ra2D  in  4 each  Decode source registers.
- UseRa1D, UseRa2D  in  1 each  source operand valid.
- RegWD  in  1  Decode instruction writes a register.
- RdD  in  4  its destination register.
- MDone  in  1  multiplier result valid (1-cycle pulse).
- MResult  in  DW  multiplier result.
- FPUDone  in  1  FPU result valid (1-cycle pulse).
- FPUResult  in  DW  FPU result.
- RegWriteW  in  1  main pipeline is using the write port this cycle.
- MGo  out  1  registered 1-cycle launch pulse to the multiplier.
- FPUGo  out  1  registered 1-cycle launch pulse to the FPU.
- StallD  out  1  combinational Decode stall.
- MCWE  out  1  scheduler register-file write enable.
- MCWA  out  4  write address.
- MCWD  out  DW  write data.
- MBusy  out  1  multiplier not IDLE.
- FPUBusy  out  1  FPU not IDLE.
- TimeoutErr  out  1  sticky: a unit was aborted.
- ProtoErr  out  1  sticky: Start arrived while that unit was not IDLE.

Behaviour:
- Reset (ResetN=0, async): both FSMs go to IDLE; counters, pending registers and holding registers cleared; every output 0. Reset mid-RUN drops the operation, and a Done arriving afterwards is ignored.
- Per-unit FSM (identical for M and FPU): IDLE -> RUN -> WB -> IDLE.
- IDLE, Start=1:
  - latch RdE into PendRd and mark it valid;
  - assert Go for exactly 1 cycle (cycle after Start);
  - clear the cycle counter; go to RUN.
  - Done in IDLE is ignored.
- RUN:
  - counter increments each cycle;
  - Done=1: capture Result into the holding register, go to WB;
  - otherwise, if TIMEOUT!=0 and counter==TIMEOUT-1: go to IDLE, set TimeoutErr, invalidate PendRd, no write;
  - Done in the same cycle as expiry: Done wins.
- WB:
  - request the write port; granted when RegWriteW=0 and this unit wins arbitration;
  - on grant, MCWE=1, MCWA=PendRd, MCWD=holding register in that same cycle (combinational); next cycle the unit is IDLE and PendRd is invalid;
  - when RegWriteW=1, no grant and the unit waits in WB indefinitely (no timeout in WB).
- Arbitration when both units are in WB and the port is free: the older issue wins.
  - Age bit: set at issue, marking the issuing unit as younger whenever the other unit is not IDLE.
  - MStart and FPUStart in the same cycle: both accepted, multiplier is older.
- Start while the unit is not IDLE: Start ignored, ProtoErr set, state unchanged. StallD prevents this in correct operation.
- StallD is asserted when any of the following holds:
  - MReqD and the multiplier is not IDLE, or FPUReqD and the FPU is not IDLE;
  - UseRa1D and Ra1D equals any valid PendRd, or equals RdE while (MStart|FPUStart);
  - the same condition for Ra2D/UseRa2D;
  - RegWD and RdD equals any valid PendRd, or equals RdE while (MStart|FPUStart) (WAW).
- StallD stays asserted through the grant cycle; it is released the cycle the unit returns to IDLE.
- Latency with no port contention: Start at cycle t, Go at t+1, Done at t+1+k, write at t+2+k, unit IDLE at t+3+k.
- MBusy/FPUBusy = state!=IDLE. TimeoutErr and ProtoErr clear only on reset.

Test Plan:
- MStart, RdE=5; MDone two cycles after MGo with MResult=0x0000_0030; RegWriteW=0 -> MGo 1 cycle; one cycle of MCWE=1, MCWA=5, MCWD=0x30; MBusy falls the next cycle.
- Multiplier pending Rd=5; Decode UseRa1D=1, Ra1D=5 -> StallD=1 every cycle until the unit is IDLE, 0 after. Ra1D=6 -> StallD=0.
- MStart (Rd=3) then FPUStart (Rd=4) two cycles later; both Done in the same cycle; RegWriteW=0 -> write Rd=3 first, then Rd=4 the next cycle.
- Multiplier in WB with RegWriteW=1 for 3 cycles -> MCWE=0 for those 3 cycles, then write in the first cycle with RegWriteW=0.
- TIMEOUT=8, FPUStart with no FPUDone -> FPU returns to IDLE 8 cycles after entering RUN; TimeoutErr=1; no MCWE; a later FPUDone is ignored.
- ResetN low while the multiplier is in RUN, then MDone after release -> all outputs 0, no write, MBusy=0; MStart while MBusy=1 -> ProtoErr=1.
